// File: rtl/fft_sample_loader.sv
// Streams one frame out of sample RAM into the FFT core, in natural or bit-reversed
// order. A 2-entry output FIFO absorbs the one-cycle RAM read latency and m_ready stalls.
module fft_sample_loader #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              bitrev_en,
    output logic [ADDR_W-1:0] ram_adr,
    output logic              ram_rd_en,
    input  logic [DATA_W-1:0] ram_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] m_index,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;
    localparam logic [CNT_W-1:0]  LAST_CNT = {1'b0, LAST_IDX};

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  rd_cnt;
    logic              rev_q;
    logic              pend;
    logic [1:0]        fifo_cnt, cnt_n;
    logic [DATA_W-1:0] data1;
    logic [ADDR_W-1:0] adr_q, adr_c, adr_rev, idx_n;
    logic [2:0]        occ;
    logic              pop, push, issue, accept;

    // Address generation: bit-reverse the low ADDR_W bits of the issue counter.
    always_comb begin
        adr_rev = '0;
        for (int i = 0; i < int'(ADDR_W); i++) begin
            adr_rev[i] = rd_cnt[int'(ADDR_W) - 1 - i];
        end
        adr_c = rev_q ? adr_rev : rd_cnt[ADDR_W-1:0];
    end

    // Issue only while the FIFO plus the in-flight read, net of this cycle's pop, has room.
    always_comb begin
        pop    = m_valid & m_ready;
        push   = pend;
        accept = (state == S_IDLE) & start;
        occ    = 3'(fifo_cnt) + 3'(pend);
        issue  = (state == S_READ) && ((occ - 3'(pop)) < 3'd2);
        cnt_n  = 2'(fifo_cnt + 2'(push) - 2'(pop));
        idx_n  = pop ? ADDR_W'(m_index + ADDR_W'(1)) : m_index;
    end

    // RAM port: address holds its last issued value between reads.
    always_comb begin
        ram_rd_en = issue;
        ram_adr   = issue ? adr_c : adr_q;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = S_READ;
            S_READ:  if (issue && (rd_cnt == LAST_CNT)) state_n = S_DRAIN;
            S_DRAIN: if (pop && m_last) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt   <= '0;
            rev_q    <= 1'b0;
            adr_q    <= '0;
            pend     <= 1'b0;
            fifo_cnt <= '0;
            m_data   <= '0;
            data1    <= '0;
            m_valid  <= 1'b0;
            m_index  <= '0;
            m_last   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (accept) begin
                rd_cnt <= '0;
                rev_q  <= bitrev_en;
            end else if (issue) begin
                rd_cnt <= CNT_W'(rd_cnt + CNT_W'(1));
                adr_q  <= adr_c;
            end
            pend <= issue;
            // Two-entry FIFO with m_data as the head register.
            case ({push, pop})
                2'b10: begin
                    if (fifo_cnt == 2'd0) m_data <= ram_data;
                    else                  data1  <= ram_data;
                end
                2'b01: m_data <= data1;
                2'b11: begin
                    if (fifo_cnt == 2'd1) begin
                        m_data <= ram_data;
                    end else begin
                        m_data <= data1;
                        data1  <= ram_data;
                    end
                end
                default: ;
            endcase
            fifo_cnt <= cnt_n;
            m_valid  <= (cnt_n != 2'd0);
            m_index  <= accept ? '0 : idx_n;
            m_last   <= (cnt_n != 2'd0) && (idx_n == LAST_IDX) && !accept;
            busy     <= (state_n == S_READ) || (state_n == S_DRAIN);
            done     <= (state_n == S_DONE);
        end
    end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Scoreboard bench for fft_sample_loader: RAM model returns RAM[i] = i, stimulus queues
// the expected stream, and a negedge monitor checks every transfer and stall invariants.
module tb_fft_sample_loader;

    localparam int N = 4096;

    typedef struct {
        logic [15:0] data;
        logic [11:0] idx;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        bitrev_en = 1'b0;
    logic [11:0] ram_adr;
    logic        ram_rd_en;
    logic [15:0] ram_data = '0;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [11:0] m_index;
    logic        m_last;
    logic        busy;
    logic        done;

    int unsigned checks = 0;
    int unsigned failures = 0;
    exp_t        exp_q[$];
    int          issued = 0;
    int          xfers = 0;
    int          xfer_total = 0;
    int          done_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic [15:0] br_head[4] = '{16'h000, 16'h800, 16'h400, 16'hC00};

    fft_sample_loader #(.ADDR_W(12), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .bitrev_en(bitrev_en),
        .ram_adr(ram_adr), .ram_rd_en(ram_rd_en), .ram_data(ram_data),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_index(m_index), .m_last(m_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Sample RAM holding RAM[i] = i, one-cycle read latency.
    always @(posedge clk) if (ram_rd_en) ram_data <= 16'(ram_adr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] rev12(input logic [11:0] v);
        logic [11:0] r;
        for (int i = 0; i < 12; i++) r[i] = v[11 - i];
        return r;
    endfunction

    // Monitor: pops and compares on each transfer; checks stall and outstanding limits.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            issued = 0;
            xfers = 0;
            prev_stall = 1'b0;
        end else begin
            if (ram_rd_en) issued++;
            if (m_valid && m_ready) begin
                xfers++;
                xfer_total++;
                if (exp_q.size() == 0) begin
                    check("unexpected_xfer", 32'(m_index), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("m_data", 32'(m_data), 32'(e.data));
                    check("m_index", 32'(m_index), 32'(e.idx));
                    check("m_last", 32'(m_last), 32'(e.last));
                end
            end
            if (ram_rd_en) check("outstanding_le2", 32'((issued - xfers) <= 2), 32'd1);
            if (prev_stall) begin
                check("valid_hold", 32'(m_valid), 32'd1);
                check("data_hold", 32'(m_data), 32'(prev_data));
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (done) done_cnt++;
        end
    end

    task automatic check_reset_outs(input string tag);
        check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_m_last"}, 32'(m_last), 32'd0);
        check({tag, "_m_index"}, 32'(m_index), 32'd0);
        check({tag, "_m_data"}, 32'(m_data), 32'd0);
        check({tag, "_ram_rd_en"}, 32'(ram_rd_en), 32'd0);
        check({tag, "_ram_adr"}, 32'(ram_adr), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic push_frame(input bit rev);
        exp_t e;
        for (int k = 0; k < N; k++) begin
            if (rev && k < 4) e.data = br_head[k];
            else              e.data = rev ? 16'(rev12(12'(k))) : 16'(k);
            e.idx  = 12'(k);
            e.last = (k == N - 1);
            exp_q.push_back(e);
        end
    endtask

    // Start is sampled at the second posedge; returns at that edge + 1.
    task automatic pulse_start(input bit rev);
        @(posedge clk); #1 start = 1'b1; bitrev_en = rev;
        @(posedge clk); #1 start = 1'b0; bitrev_en = ~rev;
    endtask

    task automatic wait_done(input bit rand_ready);
        int n;
        for (n = 0; n < 20000; n++) begin
            if (done_cnt != 0) break;
            @(posedge clk); #1;
            if (rand_ready) m_ready = 1'($urandom_range(0, 1));
        end
        check("done_timeout", 32'(done_cnt != 0), 32'd1);
        m_ready = 1'b1;
    endtask

    task automatic post_frame(input string tag);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        check({tag, "_valid_low"}, 32'(m_valid), 32'd0);
    endtask

    task automatic wait_xfers(input int base, input int target);
        int n;
        for (n = 0; n < 20000 && (xfer_total - base) < target; n++) begin
            @(posedge clk); #1;
        end
        check("xfer_wait_timeout", 32'((xfer_total - base) >= target), 32'd1);
    endtask

    initial begin
        int n;
        int base;

        // Reset values.
        repeat (3) @(posedge clk);
        #1 check_reset_outs("reset");
        rst = 1'b0;

        // Natural order, m_ready high: latency and back-to-back throughput.
        done_cnt = 0;
        push_frame(1'b0);
        m_ready = 1'b1;
        pulse_start(1'b0);
        check("busy_after_start", 32'(busy), 32'd1);
        @(posedge clk); #1 check("valid_early", 32'(m_valid), 32'd0);
        @(posedge clk); #1 check("valid_first", 32'(m_valid), 32'd1);
        n = 0;
        while (!done && n < 5000) begin
            @(posedge clk); #1 n++;
        end
        check("frame_cycles", 32'(n), 32'd4096);
        wait_done(1'b0);
        post_frame("natural");

        // Bit-reversed order.
        done_cnt = 0;
        push_frame(1'b1);
        pulse_start(1'b1);
        wait_done(1'b0);
        post_frame("bitrev");

        // Random backpressure.
        done_cnt = 0;
        push_frame(1'b0);
        pulse_start(1'b0);
        wait_done(1'b1);
        post_frame("random_ready");

        // m_ready held low: only two reads go out, head sample held.
        done_cnt = 0;
        push_frame(1'b0);
        m_ready = 1'b0;
        pulse_start(1'b0);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (ram_rd_en) n++;
        end
        check("stall_reads", 32'(n), 32'd2);
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", 32'(m_data), 32'd0);
        @(posedge clk); #1 m_ready = 1'b1;
        wait_done(1'b0);
        post_frame("stall");

        // Second start mid-frame is ignored.
        done_cnt = 0;
        push_frame(1'b0);
        base = xfer_total;
        pulse_start(1'b0);
        wait_xfers(base, 100);
        pulse_start(1'b0);
        wait_done(1'b0);
        post_frame("restart_ignored");
        check("restart_xfers", 32'(xfer_total - base), 32'd4096);

        // Asynchronous reset mid-frame, then a full fresh frame.
        push_frame(1'b0);
        base = xfer_total;
        pulse_start(1'b0);
        wait_xfers(base, 1000);
        #2 rst = 1'b1;
        #1 check_reset_outs("async_rst");
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("idle_after_rst", 32'(busy | ram_rd_en | m_valid), 32'd0);
        done_cnt = 0;
        push_frame(1'b0);
        pulse_start(1'b0);
        wait_done(1'b0);
        post_frame("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_sample_loader.md
FFT_SAMPLE_LOADER -- requirements
Module: fft_sample_loader

Interface
REQ-001 Parameter ADDR_W, default 12, sample-address width; frame length N = 2**ADDR_W (4096).
REQ-002 Parameter DATA_W, default 16, sample width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to stream one frame out of sample RAM.
REQ-006 bitrev_en  in  1  1 = read addresses in bit-reversed order, 0 = natural order; sampled on accepted start.
REQ-007 ram_adr  out  ADDR_W  read address driven to the sample RAM circuit port.
REQ-008 ram_rd_en  out  1  high in each cycle a read is issued.
REQ-009 ram_data  in  DATA_W  RAM read data, valid exactly one cycle after the issuing ram_rd_en cycle.
REQ-010 m_data  out  DATA_W  sample to the FFT core.
REQ-011 m_valid  out  1  m_data holds a valid sample.
REQ-012 m_ready  in  1  FFT core accepts the sample; transfer = m_valid & m_ready.
REQ-013 m_index  out  ADDR_W  stream position (0..N-1) of the sample on m_data.
REQ-014 m_last  out  1  high with the sample at m_index = N-1.
REQ-015 busy  out  1  high from accepted start until the final transfer completes.
REQ-016 done  out  1  one-cycle pulse in the cycle after the final transfer.

Function
REQ-017 FSM states: IDLE, READ (issuing addresses), DRAIN (all N issued, samples still buffered or in flight), DONE.
REQ-018 IDLE -> READ on start; start in any other state is ignored.
REQ-019 READ: issue counter rd_cnt (ADDR_W+1 bits) starts at 0; ram_adr = rd_cnt[ADDR_W-1:0] with the bits reversed when bitrev_en latched high, otherwise unchanged.
REQ-020 READ -> DRAIN in the cycle the read with rd_cnt = N-1 issues; DRAIN -> DONE on the transfer with m_last high; DONE -> IDLE unconditionally after one cycle (done = 1 in DONE).
REQ-021 Returned data enters a 2-entry output FIFO one cycle after issue; m_data/m_valid come from the FIFO head; no combinational path from m_ready to m_data.
REQ-022 Occupancy = FIFO entries + reads in flight (0 or 1); a read is issued only if occupancy minus this cycle's transfer < 2; no sample is ever dropped or duplicated.
REQ-023 With m_ready held high, one read issues per cycle and throughput is one sample per cycle; first m_valid rises 2 cycles after the start cycle.
REQ-024 m_index counts transfers from 0 and increments on each transfer; it reflects stream order, not RAM address.
REQ-025 ram_adr holds its last value when ram_rd_en is low; ram_rd_en is never high outside READ.
REQ-026 Simultaneous FIFO push and pop in one cycle leaves occupancy unchanged and preserves ordering.
REQ-027 m_ready low indefinitely stalls issuing after at most 2 outstanding samples; operation resumes without loss when m_ready returns high.

Reset
REQ-028 While rst is high: state = IDLE, rd_cnt = 0, FIFO empty, m_valid = 0, m_last = 0, m_index = 0, m_data = 0, ram_rd_en = 0, ram_adr = 0, busy = 0, done = 0.
REQ-029 rst asserted mid-frame aborts immediately; the in-flight read is discarded; after release the block waits in IDLE for a new start.

Verification
REQ-030 RAM[i] = i, bitrev_en = 0, m_ready = 1, pulse start -> 4096 transfers m_data = 0..4095 on consecutive cycles, m_last at 4095, done one cycle later, busy low thereafter.
REQ-031 RAM[i] = i, bitrev_en = 1 -> m_index 0,1,2,3 carry m_data 0x000, 0x800, 0x400, 0xC00; m_index 4095 carries 0xFFF.
REQ-032 m_ready random (50%) -> exact ordered sequence 0..4095 received, never more than 2 reads outstanding, m_valid never drops while waiting for m_ready.
REQ-033 Hold m_ready = 0 after start for 20 cycles -> ram_rd_en high for exactly 2 cycles, m_data = RAM[0] held stable; release -> stream continues from index 1.
REQ-034 Second start pulse at transfer 100 -> ignored; frame completes normally with exactly 4096 transfers and a single done pulse.
REQ-035 Assert rst at transfer 1000 -> outputs return to REQ-028 values asynchronously; a new start yields a full frame beginning at m_index 0.
